// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter slice: op codes and default geometry.
package pc_pkg;

    localparam int ADDR_W_DEF      = 19;
    localparam int OFS_W_DEF       = 10;
    localparam int STACK_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_INC    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_CALL   = 3'd4,
        OP_RET    = 3'd5,
        OP_CLR    = 3'd6
    } pc_op_t;

endpackage

// File: rtl/pc_stack_unit_if.sv
// Control-unit <-> program-counter bus: op request in, fetch/execute addresses and stack status out.
interface pc_stack_unit_if #(
    parameter int ADDR_W      = 19,
    parameter int OFS_W       = 10,
    parameter int STACK_DEPTH = 8
);
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [OFS_W-1:0]  offset;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] execadd;
    logic [SP_W-1:0]   sp;
    logic              ovf;
    logic              unf;

    modport master (output en, op, target, offset,
                    input  pc, execadd, sp, ovf, unf);
    modport slave  (input  en, op, target, offset,
                    output pc, execadd, sp, ovf, unf);
endinterface

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO; read data is the current top entry, available combinationally.
module pc_ret_stack #(
    parameter int ADDR_W      = 19,
    parameter int STACK_DEPTH = 8,
    localparam int SP_W       = $clog2(STACK_DEPTH) + 1,
    localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] wdata,
    output logic [ADDR_W-1:0] rdata,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);
    logic [ADDR_W-1:0] mem_r [STACK_DEPTH];
    logic [SP_W-1:0]   sp_r;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;

    // With sp a power of two plus one bit, the low bits address the next free slot;
    // decrementing them modulo the depth addresses the top entry.
    assign wr_idx_s = sp_r[IDX_W-1:0];
    assign rd_idx_s = wr_idx_s - {{(IDX_W-1){1'b0}}, 1'b1};
    assign rdata    = mem_r[rd_idx_s];
    assign sp       = sp_r;
    assign full     = (sp_r == SP_W'(STACK_DEPTH));
    assign empty    = (sp_r == {SP_W{1'b0}});

    // Occupancy counter; clear wins over push/pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sp_r <= {SP_W{1'b0}};
        end else if (clr) begin
            sp_r <= {SP_W{1'b0}};
        end else if (push) begin
            sp_r <= sp_r + {{(SP_W-1){1'b0}}, 1'b1};
        end else if (pop) begin
            sp_r <= sp_r - {{(SP_W-1){1'b0}}, 1'b1};
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_r[wr_idx_s] <= wdata;
        end
    end
endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch and call/return via an internal return stack.
// Optional PC_EXCVEC_EN: stack overflow/underflow redirects the next pc to EXC_VEC.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int                 ADDR_W      = ADDR_W_DEF,
    parameter int                 OFS_W       = OFS_W_DEF,
    parameter int                 STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
    parameter logic [ADDR_W-1:0]  EXC_VEC     = 19'h7FF00,
    localparam int                SP_W        = $clog2(STACK_DEPTH) + 1
) (
    input  logic           CLK,
    input  logic           RST_N,
    pc_stack_unit_if.slave bus
);
`ifdef PC_EXCVEC_EN
    localparam logic EXC_EN = 1'b1;
`else
    localparam logic EXC_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] execadd_r;
    logic              ovf_r;
    logic              unf_r;

    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] ofs_ext_s;
    logic [ADDR_W-1:0] stk_rdata_s;
    logic [SP_W-1:0]   stk_sp_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              clr_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    pc_op_t            op_s;

    assign op_s      = pc_op_t'(bus.op);
    assign pc_inc_s  = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign ofs_ext_s = {{(ADDR_W-OFS_W){bus.offset[OFS_W-1]}}, bus.offset};

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (clr_s & bus.en),
        .push  (push_s & bus.en),
        .pop   (pop_s & bus.en),
        .wdata (pc_inc_s),
        .rdata (stk_rdata_s),
        .sp    (stk_sp_s),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

    // Next-pc select and stack/flag requests; a failed CALL/RET never touches the stack.
    always_comb begin
        pc_next_s = pc_r;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        clr_s     = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        case (op_s)
            OP_NOP:    pc_next_s = pc_r;
            OP_INC:    pc_next_s = pc_inc_s;
            OP_LOAD:   pc_next_s = bus.target;
            OP_BRANCH: pc_next_s = pc_r + ofs_ext_s;
            OP_CALL: begin
                if (stk_full_s) begin
                    ovf_set_s = 1'b1;
                    pc_next_s = EXC_EN ? EXC_VEC : bus.target;
                end else begin
                    push_s    = 1'b1;
                    pc_next_s = bus.target;
                end
            end
            OP_RET: begin
                if (stk_empty_s) begin
                    unf_set_s = 1'b1;
                    pc_next_s = EXC_EN ? EXC_VEC : pc_inc_s;
                end else begin
                    pop_s     = 1'b1;
                    pc_next_s = stk_rdata_s;
                end
            end
            OP_CLR: begin
                clr_s     = 1'b1;
                pc_next_s = RESET_VEC;
            end
            default:   pc_next_s = pc_r;
        endcase
    end

    // PC, execute address and sticky error flags; everything holds while stalled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_r      <= RESET_VEC;
            execadd_r <= RESET_VEC;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else if (bus.en) begin
            pc_r      <= pc_next_s;
            execadd_r <= pc_r;
            ovf_r     <= ovf_r | ovf_set_s;
            unf_r     <= unf_r | unf_set_s;
        end
    end

    assign bus.pc      = pc_r;
    assign bus.execadd = execadd_r;
    assign bus.sp      = stk_sp_s;
    assign bus.ovf     = ovf_r;
    assign bus.unf     = unf_r;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit; expected values are hand-computed constants.
module tb_pc_stack_unit;
    import pc_pkg::*;

    localparam int ADDR_W = 19;
    localparam int OFS_W  = 10;
    localparam int DEPTH  = 8;
`ifdef PC_EXCVEC_EN
    localparam logic [31:0] OVF_PC = 32'h7FF00;
    localparam logic [31:0] UNF_PC = 32'h7FF00;
`else
    localparam logic [31:0] OVF_PC = 32'h40;
    localparam logic [31:0] UNF_PC = 32'h11;
`endif

    logic CLK;
    logic RST_N;
    int   tests_run;
    int   tests_failed;

    pc_stack_unit_if #(.ADDR_W(ADDR_W), .OFS_W(OFS_W), .STACK_DEPTH(DEPTH)) bus ();

    pc_stack_unit #(
        .ADDR_W      (ADDR_W),
        .OFS_W       (OFS_W),
        .STACK_DEPTH (DEPTH),
        .RESET_VEC   (19'h0),
        .EXC_VEC     (19'h7FF00)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic step(input pc_op_t o, input logic [ADDR_W-1:0] tgt, input logic [OFS_W-1:0] ofs);
        bus.op     = o;
        bus.target = tgt;
        bus.offset = ofs;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] exp_ret;
        tests_run    = 0;
        tests_failed = 0;
        RST_N        = 1'b0;
        bus.en       = 1'b0;
        bus.op       = OP_NOP;
        bus.target   = '0;
        bus.offset   = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_exec", 32'(bus.execadd), 32'h0);
        check("rst_sp", 32'(bus.sp), 32'h0);
        check("rst_ovf", 32'(bus.ovf), 32'h0);
        check("rst_unf", 32'(bus.unf), 32'h0);
        RST_N  = 1'b1;
        bus.en = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            step(OP_INC, '0, '0);
            check("inc_pc", 32'(bus.pc), 32'(i));
            check("inc_exec", 32'(bus.execadd), 32'(i - 1));
        end
        check("inc_sp", 32'(bus.sp), 32'h0);

        step(pc_op_t'(3'd7), 19'h123, '0);
        check("op7_hold", 32'(bus.pc), 32'h3);

        step(OP_LOAD, 19'h7FFFF, '0);
        check("load_top", 32'(bus.pc), 32'h7FFFF);
        step(OP_INC, '0, '0);
        check("inc_wrap", 32'(bus.pc), 32'h0);
        check("inc_wrap_exec", 32'(bus.execadd), 32'h7FFFF);

        step(OP_LOAD, 19'h5, '0);
        step(OP_BRANCH, '0, 10'h3F8);
        check("br_neg_wrap", 32'(bus.pc), 32'h7FFFD);
        step(OP_LOAD, 19'h5, '0);
        step(OP_BRANCH, '0, 10'h004);
        check("br_pos", 32'(bus.pc), 32'h9);

        step(OP_LOAD, 19'h100, '0);
        step(OP_CALL, 19'h2000, '0);
        check("call_pc", 32'(bus.pc), 32'h2000);
        check("call_sp", 32'(bus.sp), 32'h1);
        step(OP_INC, '0, '0);
        check("call_inc", 32'(bus.pc), 32'h2001);
        step(OP_RET, '0, '0);
        check("ret_pc", 32'(bus.pc), 32'h101);
        check("ret_sp", 32'(bus.sp), 32'h0);

        // Nested calls: call i jumps to 'h1000+16*i and pushes the caller's pc+1.
        step(OP_LOAD, 19'h300, '0);
        for (int i = 0; i < DEPTH; i++) begin
            step(OP_CALL, 19'(32'h1000 + 32'(i) * 32'h10), '0);
            check("nest_sp", 32'(bus.sp), 32'(i + 1));
        end
        step(OP_CALL, 19'h40, '0);
        check("ovf_pc", 32'(bus.pc), OVF_PC);
        check("ovf_sp", 32'(bus.sp), 32'h8);
        check("ovf_flag", 32'(bus.ovf), 32'h1);
        for (int k = 0; k < DEPTH; k++) begin
            exp_ret = (k == DEPTH - 1) ? 32'h301 : 32'h1000 + 32'(DEPTH - 2 - k) * 32'h10 + 32'h1;
            step(OP_RET, '0, '0);
            check("lifo_pc", 32'(bus.pc), exp_ret);
            check("lifo_sp", 32'(bus.sp), 32'(DEPTH - 1 - k));
        end

        step(OP_LOAD, 19'h10, '0);
        step(OP_RET, '0, '0);
        check("unf_pc", 32'(bus.pc), UNF_PC);
        check("unf_flag", 32'(bus.unf), 32'h1);
        check("unf_sp", 32'(bus.sp), 32'h0);
        step(OP_CALL, 19'h77, '0);
        step(OP_CLR, '0, '0);
        check("clr_pc", 32'(bus.pc), 32'h0);
        check("clr_sp", 32'(bus.sp), 32'h0);
        check("clr_unf", 32'(bus.unf), 32'h1);
        check("clr_ovf", 32'(bus.ovf), 32'h1);

        step(OP_LOAD, 19'h20, '0);
        step(OP_CALL, 19'h30, '0);
        bus.en = 1'b0;
        step(OP_LOAD, 19'h55, '0);
        check("stall_pc", 32'(bus.pc), 32'h30);
        check("stall_exec", 32'(bus.execadd), 32'h20);
        check("stall_sp", 32'(bus.sp), 32'h1);
        bus.en = 1'b1;

        #2;
        RST_N = 1'b0;
        #1;
        check("async_pc", 32'(bus.pc), 32'h0);
        check("async_exec", 32'(bus.execadd), 32'h0);
        check("async_sp", 32'(bus.sp), 32'h0);
        check("async_ovf", 32'(bus.ovf), 32'h0);
        check("async_unf", 32'(bus.unf), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
